// File: rtl/eval_seq_pkg.sv
// rtl/eval_seq_pkg.sv - shared states, defaults and memory field layout for eval_sequencer
package eval_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_IN,
        ST_RD_EXP,
        ST_LAT_EXP,
        ST_SETTLE,
        ST_COMPARE,
        ST_DONE,
        ST_ACK
    } state_t;

    localparam int N_OUT_DEF = 8;
    localparam int SUM_W_DEF = 32;

    // Odd table words: expected outputs in the low field, valid mask directly above.
    localparam int EXP_LSB   = 0;
    localparam int VALID_LSB = N_OUT_DEF;

    function automatic logic [31:0] clamp_count(input logic [31:0] req, input logic [31:0] lim);
        return (req > lim) ? lim : req;
    endfunction

endpackage

// File: rtl/eval_err_accum.sv
// rtl/eval_err_accum.sv - per-output saturating mismatch accumulators
module eval_err_accum #(
    parameter int N_OUT = 8,
    parameter int SUM_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   en,
    input  logic [N_OUT-1:0]       err,
    output logic [N_OUT*SUM_W-1:0] sums
);

    logic [SUM_W-1:0] sum_q [N_OUT];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            for (int k = 0; k < N_OUT; k++) begin
                sum_q[k] <= '0;
            end
        end else if (en) begin
            for (int k = 0; k < N_OUT; k++) begin
                // A lane pinned at all-ones stays there; the others keep counting.
                if (err[k] && (sum_q[k] != {SUM_W{1'b1}})) begin
                    sum_q[k] <= sum_q[k] + SUM_W'(1);
                end
            end
        end
    end

    for (genvar g = 0; g < N_OUT; g++) begin : g_lane
        assign sums[g*SUM_W +: SUM_W] = sum_q[g];
    end

endmodule

// File: rtl/eval_sequencer.sv
// rtl/eval_sequencer.sv - runs one fitness evaluation over the test-vector table and reports via done/feedback
module eval_sequencer
    import eval_seq_pkg::*;
#(
    parameter int N_OUT  = N_OUT_DEF,
    parameter int IN_W   = 32,
    parameter int SUM_W  = SUM_W_DEF,
    parameter int ADDR_W = 16,
    parameter int SETTLE = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_processing_chrom,
    input  logic [31:0]            sequences_to_process,
    input  logic                   done_processing_feedback,
    output logic                   ready_to_process,
    output logic                   done_processing_chrom,
    output logic [N_OUT*SUM_W-1:0] error_sum,
    output logic [ADDR_W-1:0]      mem_address,
    output logic                   mem_chipselect,
    output logic                   mem_clken,
    output logic                   mem_write,
    output logic [3:0]             mem_byteenable,
    input  logic [31:0]            mem_readdata,
    output logic [IN_W-1:0]        circ_in,
    input  logic [N_OUT-1:0]       circ_out
);

    localparam logic [31:0] N_MAX     = 32'(1) << (ADDR_W - 1);
    localparam int          CNT_W     = $clog2(SETTLE + 1);
    localparam int          VALID_OFS = EXP_LSB + N_OUT;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  n_q, i_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [N_OUT-1:0]   exp_q, valid_q;
    logic [IN_W-1:0]    circ_in_q;
    logic               done_q;
    logic [31:0]        n_req;
    logic               accept;
    logic               unused_bits;

    // Clamping n keeps 2i+1 inside the address space, so the address never wraps.
    assign n_req       = clamp_count(sequences_to_process, N_MAX);
    assign accept      = (state_q == ST_IDLE) && start_processing_chrom;
    assign unused_bits = ^{mem_readdata, n_req};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_processing_chrom) begin
                    state_d = (n_req == 32'd0) ? ST_DONE : ST_RD_IN;
                end
            end
            ST_RD_IN:   state_d = ST_RD_EXP;
            ST_RD_EXP:  state_d = ST_LAT_EXP;
            ST_LAT_EXP: state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_COMPARE;
                end
            end
            ST_COMPARE: begin
                state_d = ((i_q + ADDR_W'(1)) == n_q) ? ST_DONE : ST_RD_IN;
            end
            ST_DONE: begin
                if (done_processing_feedback) begin
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                if (!done_processing_feedback && !start_processing_chrom) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            n_q       <= '0;
            i_q       <= '0;
            cnt_q     <= '0;
            exp_q     <= '0;
            valid_q   <= '0;
            circ_in_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            // Done is registered off the DONE state and drops as soon as feedback is seen.
            done_q  <= (state_q == ST_DONE) && !done_processing_feedback;
            case (state_q)
                ST_IDLE: begin
                    if (start_processing_chrom) begin
                        n_q <= n_req[ADDR_W-1:0];
                        i_q <= '0;
                    end
                end
                ST_RD_EXP: circ_in_q <= IN_W'(mem_readdata);
                ST_LAT_EXP: begin
                    exp_q   <= mem_readdata[EXP_LSB +: N_OUT];
                    valid_q <= mem_readdata[VALID_OFS +: N_OUT];
                    cnt_q   <= CNT_W'(SETTLE);
                end
                ST_SETTLE:  cnt_q <= cnt_q - CNT_W'(1);
                ST_COMPARE: i_q <= i_q + ADDR_W'(1);
                default: ;
            endcase
        end
    end

    eval_err_accum #(
        .N_OUT (N_OUT),
        .SUM_W (SUM_W)
    ) u_accum (
        .clk   (clk),
        .reset (reset),
        .clear (accept),
        .en    (state_q == ST_COMPARE),
        .err   ((circ_out ^ exp_q) & valid_q),
        .sums  (error_sum)
    );

    assign ready_to_process      = (state_q == ST_IDLE);
    assign done_processing_chrom = done_q;
    assign mem_chipselect        = (state_q == ST_RD_IN) || (state_q == ST_RD_EXP);
    assign mem_clken             = mem_chipselect;
    assign mem_write             = 1'b0;
    assign mem_byteenable        = 4'hF;
    assign mem_address           = {i_q[ADDR_W-2:0], (state_q == ST_RD_EXP)};
    assign circ_in               = circ_in_q;

endmodule

// File: tb/tb_eval_sequencer.sv
// tb/tb_eval_sequencer.sv - directed self-checking bench for eval_sequencer
module tb_eval_sequencer;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    // DUT1: default parameters
    logic         start1, fb1, ready1, done1, cs1, clken1, wr1;
    logic [31:0]  seq1, rd1, circ_in1;
    logic [255:0] esum1;
    logic [15:0]  addr1;
    logic [3:0]   be1;
    logic [7:0]   circ_out1;
    logic         mode;
    logic [31:0]  mem1 [0:63];

    // DUT2: 4-bit accumulators, SETTLE=1
    logic         start2, fb2, ready2, done2, cs2, clken2, wr2;
    logic [31:0]  seq2, rd2, circ_in2;
    logic [31:0]  esum2;
    logic [15:0]  addr2;
    logic [3:0]   be2;
    logic [7:0]   circ_out2;
    logic [31:0]  mem2 [0:63];

    int vectors = 0;
    int errors  = 0;
    logic [15:0] addr_log [$];

    eval_sequencer dut1 (
        .clk(clk), .reset(reset), .start_processing_chrom(start1),
        .sequences_to_process(seq1), .done_processing_feedback(fb1),
        .ready_to_process(ready1), .done_processing_chrom(done1), .error_sum(esum1),
        .mem_address(addr1), .mem_chipselect(cs1), .mem_clken(clken1), .mem_write(wr1),
        .mem_byteenable(be1), .mem_readdata(rd1), .circ_in(circ_in1), .circ_out(circ_out1)
    );

    eval_sequencer #(.SUM_W(4), .SETTLE(1)) dut2 (
        .clk(clk), .reset(reset), .start_processing_chrom(start2),
        .sequences_to_process(seq2), .done_processing_feedback(fb2),
        .ready_to_process(ready2), .done_processing_chrom(done2), .error_sum(esum2),
        .mem_address(addr2), .mem_chipselect(cs2), .mem_clken(clken2), .mem_write(wr2),
        .mem_byteenable(be2), .mem_readdata(rd2), .circ_in(circ_in2), .circ_out(circ_out2)
    );

    always @(posedge clk) rd1 <= mem1[addr1[5:0]];
    always @(posedge clk) rd2 <= mem2[addr2[5:0]];
    always @(posedge clk) if (cs1) addr_log.push_back(addr1);

    assign circ_out1 = mode ? 8'hFF : ~circ_in1[7:0];
    assign circ_out2 = circ_in2[7:0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run1(input logic [31:0] n, output int cyc);
        seq1   = n;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        seq1   = 32'd100;
        chk("accept_ready_low", ready1, 0);
        cyc = 0;
        while (!done1 && cyc < 300) begin
            tick();
            cyc++;
        end
    endtask

    task automatic ack1();
        fb1 = 1'b1;
        tick();
        fb1 = 1'b0;
        tick();
    endtask

    int   cyc;
    logic held;

    initial begin
        reset = 1'b1; start1 = 0; fb1 = 0; seq1 = 0; start2 = 0; fb2 = 0; seq2 = 0; mode = 0;
        for (int a = 0; a < 64; a++) begin
            mem1[a] = 32'h0;
            mem2[a] = 32'h0;
        end
        tick();
        tick();
        reset = 1'b0;
        chk("rst_ready", ready1, 1);
        chk("rst_done", done1, 0);
        chk("rst_esum", esum1, 0);
        chk("rst_circ_in", circ_in1, 0);
        chk("rst_cs", cs1, 0);
        chk("rst_addr", addr1, 0);
        chk("mem_write", wr1, 0);
        chk("mem_be", be1, 4'hF);

        // n = 0: immediate done, no memory traffic
        addr_log.delete();
        run1(0, cyc);
        chk("n0_cycles", cyc, 1);
        chk("n0_esum", esum1, 0);
        chk("n0_no_access", addr_log.size(), 0);
        ack1();
        chk("n0_idle", ready1, 1);

        // n = 1: A5 -> circuit 5A vs expected 0F, all valid -> err 0x55
        mem1[0] = 32'h0000_00A5;
        mem1[1] = 32'h0000_FF0F;
        mode = 0;
        addr_log.delete();
        run1(1, cyc);
        chk("n1_cycles", cyc, 9);
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("n1_lane%0d", k), esum1[k*32 +: 32], (k % 2 == 0) ? 32'd1 : 32'd0);
        end
        chk("n1_addr_cnt", addr_log.size(), 2);
        chk("n1_addr0", addr_log[0], 0);
        chk("n1_addr1", addr_log[1], 1);
        chk("n1_circ_in", circ_in1, 32'h0000_00A5);
        ack1();

        // valid mask zero: sums cleared at start and stay 0
        mem1[1] = 32'h0000_000F;
        run1(1, cyc);
        chk("mask0_esum", esum1, 0);
        ack1();

        // n = 3, expected 7F, circuit FF -> only lane 7 mismatches
        mem1[0] = 32'h11; mem1[2] = 32'h22; mem1[4] = 32'h33;
        mem1[1] = 32'h0000_FF7F; mem1[3] = 32'h0000_FF7F; mem1[5] = 32'h0000_FF7F;
        mode = 1;
        addr_log.delete();
        run1(3, cyc);
        chk("n3_cycles", cyc, 25);
        chk("n3_esum", esum1, 256'd3 << 224);
        chk("n3_addr_cnt", addr_log.size(), 6);
        for (int k = 0; k < 6; k++) begin
            chk($sformatf("n3_addr%0d", k), addr_log[k], 16'(k));
        end
        chk("n3_circ_in", circ_in1, 32'h33);

        // handshake
        held = 1'b1;
        repeat (10) begin
            tick();
            held &= done1;
        end
        chk("hs_done_held", held, 1);
        fb1 = 1'b1;
        start1 = 1'b1;
        tick();
        chk("hs_done_drop", done1, 0);
        repeat (3) tick();
        chk("hs_no_restart", ready1, 0);
        fb1 = 1'b0;
        tick();
        chk("hs_start_still_high", ready1, 0);
        chk("hs_esum_stable", esum1, 256'd3 << 224);
        start1 = 1'b0;
        tick();
        chk("hs_idle", ready1, 1);
        chk("hs_no_access", addr_log.size(), 6);

        // reset during second sequence's settle window
        mem1[0] = 32'hA5; mem1[1] = 32'h0000_FF0F;
        mem1[2] = 32'hA5; mem1[3] = 32'h0000_FF0F;
        mode = 0;
        seq1 = 2;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (12) tick();
        chk("mid_partial_sum", esum1[31:0], 1);
        chk("mid_circ_in", circ_in1, 32'hA5);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mid_rst_ready", ready1, 1);
        chk("mid_rst_done", done1, 0);
        chk("mid_rst_esum", esum1, 0);
        chk("mid_rst_circ_in", circ_in1, 0);
        chk("mid_rst_cs", cs1, 0);
        chk("mid_rst_addr", addr1, 0);

        // saturation: 20 mismatches on lane 0, 5 on lane 1, 4-bit sums
        for (int i = 0; i < 20; i++) begin
            mem2[2*i]   = (i < 5) ? 32'h3 : 32'h1;
            mem2[2*i+1] = 32'h0000_0300;
        end
        seq2 = 20;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        cyc = 0;
        while (!done2 && cyc < 300) begin
            tick();
            cyc++;
        end
        chk("sat_cycles", cyc, 101);
        chk("sat_esum", esum2, 32'h0000_005F);
        fb2 = 1'b1;
        tick();
        fb2 = 1'b0;
        tick();
        chk("sat_idle", ready2, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/eval_sequencer.md
# eval_sequencer

Fabric-side controller that runs one chromosome fitness evaluation on the evolvable circuit for the HPS. On a PIO start request, it walks the test-vector table in the dual-port on-chip memory, fetching one input vector and one expected/valid word per sequence. It drives each input vector into the circuit, waits a fixed settle time, compares the circuit outputs, and accumulates per-output mismatch counts into the `error_sum` registers. Completion is reported through a four-phase done/feedback handshake with software.

## Interface
Parameters:
- `N_OUT`, 8, number of circuit outputs and error accumulators.
- `IN_W`, 32, circuit input vector width.
- `SUM_W`, 32, width of each error accumulator.
- `ADDR_W`, 16, memory word-address width.
- `SETTLE`, 4, wait cycles after each input change (≥1).

Ports:
- `clk`  in  1  single clock. All logic is on this clock.
- `reset`  in  1  synchronous, active-high reset.
- `start_processing_chrom`  in  1  HPS start request (level).
- `sequences_to_process`  in  32  number of sequences to run, latched at start.
- `done_processing_feedback`  in  1  HPS acknowledge of done.
- `ready_to_process`  out  1  high only in IDLE.
- `done_processing_chrom`  out  1  evaluation complete.
- `error_sum`  out  N_OUT*SUM_W  flattened accumulators; lane k is bits [k*SUM_W +: SUM_W].
- `mem_address`  out  ADDR_W  word address.
- `mem_chipselect`  out  1  read strobe.
- `mem_clken`  out  1  equals `mem_chipselect`.
- `mem_write`  out  1  constant 0.
- `mem_byteenable`  out  4  constant 4'hF.
- `mem_readdata`  in  32  read data, valid one cycle after the address cycle.
- `circ_in`  out  IN_W  registered input vector to the circuit.
- `circ_out`  in  N_OUT  circuit outputs.

## Operation
Memory layout for sequence i:
- word 2i holds the input vector.
- word 2i+1 holds expected outputs in bits [N_OUT-1:0] and the valid mask in bits [2*N_OUT-1:N_OUT]. Upper bits are ignored.

State machine:
- IDLE: `ready_to_process`=1. If `start_processing_chrom`=1, then:
  - latch n = min(`sequences_to_process`, 2^(ADDR_W-1));
  - clear all sums;
  - set i=0;
  - go to DONE if n==0, else go to RD_IN.
- RD_IN: address 2i, chipselect=1. Next state is RD_EXP.
- RD_EXP: address 2i+1, chipselect=1. Register `mem_readdata` into `circ_in`. Next state is LAT_EXP.
- LAT_EXP: register the expected and valid fields. Load the settle counter with SETTLE. Next state is SETTLE.
- SETTLE: decrement the counter. Move to COMPARE on the cycle the counter reaches 0.
- COMPARE:
  - err = (`circ_out` ^ expected) & valid.
  - For each lane k, sum_k += err[k], saturating at all-ones.
  - i++.
  - Go to DONE if i==n, else go to RD_IN.
- DONE: `done_processing_chrom`=1. Go to ACK when `done_processing_feedback`=1.
- ACK: `done_processing_chrom`=0. Go to IDLE when `done_processing_feedback`=0 and `start_processing_chrom`=0.

Data rules:
- `error_sum` is stable from DONE until the next accepted start. It is cleared only at start or on reset.
- `circ_in` holds the last vector after the run.
- Changes to `sequences_to_process` during a run are ignored.
- A start request outside IDLE is ignored. Start held high through ACK does not retrigger.

## Timing
Reset values:
- state = IDLE, `ready_to_process`=1;
- `done_processing_chrom`=0;
- `error_sum`=0, `circ_in`=0;
- `mem_chipselect`=0, `mem_address`=0.

Latency:
- Each sequence takes SETTLE+4 cycles, from RD_IN through COMPARE.
- `circ_in` is stable for SETTLE+2 cycles before `circ_out` is sampled at the end of COMPARE.
- Full run: 1 + n*(SETTLE+4) cycles from the start-accept edge to `done_processing_chrom` rising.
- n==0: `done_processing_chrom` is high in the cycle after accept, with no memory access.
- `done_processing_chrom` falls in the cycle after `done_processing_feedback` is sampled high.

Boundary behaviour:
- Reset asserted in any state returns to the reset values on the next edge. No partial sums survive.
- Saturation: a lane at all-ones stays at all-ones. Other lanes keep counting.
- The address never wraps, because n is clamped.

## Structure
- Package `eval_seq_pkg`:
  - state enum (IDLE, RD_IN, RD_EXP, LAT_EXP, SETTLE, COMPARE, DONE, ACK);
  - default N_OUT, SUM_W;
  - memory field offsets: EXP_LSB=0, VALID_LSB=N_OUT.
- Sub-module `eval_err_accum`: N_OUT saturating accumulator lanes with clear, enable and an err vector input.

## Test plan
- n=0, start pulse: `ready_to_process` drops and `done_processing_chrom`=1 the next cycle. `error_sum`=0, `mem_chipselect` never asserted.
- n=1, SETTLE=4, word0=0x000000A5, word1=0x0000FF0F, circuit model `circ_out`=~in[7:0]=0x5A:
  - lanes 0,2,4,6 = 1, others = 0;
  - done 9 cycles after accept;
  - addresses 0,1.
- Same as above with word1=0x0000000F (valid mask 0x00): all sums are 0.
- n=3, every expected word 0x0000FF7F, circuit output 0xFF on each vector:
  - sum7=3, others 0;
  - address sequence 0,1,2,3,4,5.
- Handshake:
  - hold feedback low 10 cycles: done stays high;
  - raise feedback: done drops next cycle;
  - keep start high: no restart, `ready_to_process`=0;
  - drop both: IDLE.
- Reset asserted mid-SETTLE: all outputs at reset values next cycle.
- Saturation, with SUM_W=4: 20 mismatches on lane 0 leave sum0=15.
